nbcac_encoder_bank: RTL

Multi-channel, flow-controlled NBCAC encoder for wide on-chip buses. It splits a wide data word into NCH 13-bit lanes and encodes each lane to an 18-bit crosstalk-avoidance codeword with one `nbcac_13di_encoder_core` instance per lane. It adds valid/ready handshaking, a one-word skid buffer and per-lane hold. It sits between the data producer and the coded wire bundle and replaces the fixed single-lane registered encoder.

---
 rtl/nbcac_encoder_bank.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/nbcac_encoder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : nbcac_encoder_bank (with nbcac_13di_encoder_core)
//  Description : Multi-lane, valid/ready flow-controlled crosstalk-avoidance
//                encoder. The wide input word is split into NCH 13-bit lanes.
//                Each lane is mapped to an 18-bit forbidden-pattern-free
//                codeword. A one-word skid buffer lets in_ready be registered.
//                Per-lane enables let a lane hold its previous codeword.
//  Options     : NBCAC_ENC_CNT_EN adds the word_cnt output-transfer counter.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// nbcac_13di_encoder_core
// Maps a 13-bit value v to the v-th 18-bit codeword, counting in ascending
// numeric order. A codeword is valid when it contains no "010" and no "101"
// in adjacent bits. There are 8362 such words, which is enough for all 8192
// inputs. The encoder works from MSB to LSB and decides one bit per step. At
// each step it compares the remaining rank with the number of valid
// completions that start with a 0 bit.
// ----------------------------------------------------------------------------
module nbcac_13di_encoder_core (
    input  logic [12:0] data_i,
    output logic [17:0] code_o
);

    // Number of completions of r more bits after a free state, i.e. after
    // two equal bits or at the start of the word. This value is Fib(r+2).
    function automatic logic [13:0] free_cnt(input int r);
        logic [13:0] v;
        case (r)
            0:       v = 14'd1;
            1:       v = 14'd2;
            2:       v = 14'd3;
            3:       v = 14'd5;
            4:       v = 14'd8;
            5:       v = 14'd13;
            6:       v = 14'd21;
            7:       v = 14'd34;
            8:       v = 14'd55;
            9:       v = 14'd89;
            10:      v = 14'd144;
            11:      v = 14'd233;
            12:      v = 14'd377;
            13:      v = 14'd610;
            14:      v = 14'd987;
            15:      v = 14'd1597;
            16:      v = 14'd2584;
            default: v = 14'd4181;
        endcase
        return v;
    endfunction

    // Number of completions of r more bits after a forced state, i.e. after
    // the last two bits differ. In that case the next bit must repeat the
    // last bit.
    function automatic logic [13:0] forced_cnt(input int r);
        return (r == 0) ? 14'd1 : free_cnt(r - 1);
    endfunction

    logic [13:0] rem;
    logic [13:0] cnt0;
    logic        last;
    logic        forced;
    logic        bit_v;

    // Unrank the input value into its codeword, one bit per step from MSB to LSB.
    always_comb begin
        code_o = '0;
        rem    = {1'b0, data_i};
        cnt0   = free_cnt(17);
        forced = 1'b0;
        bit_v  = 1'b0;
        if (rem >= cnt0) begin
            code_o[17] = 1'b1;
            rem        = rem - cnt0;
        end
        last = code_o[17];
        for (int i = 16; i >= 0; i--) begin
            if (forced) begin
                bit_v  = last;
                forced = 1'b0;
            end else begin
                cnt0 = last ? forced_cnt(i) : free_cnt(i);
                if (rem < cnt0) begin
                    bit_v = 1'b0;
                end else begin
                    bit_v = 1'b1;
                    rem   = rem - cnt0;
                end
                forced = (bit_v != last);
            end
            code_o[i] = bit_v;
            last      = bit_v;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// nbcac_encoder_bank
// ----------------------------------------------------------------------------
module nbcac_encoder_bank #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [13*NCH-1:0]   datain,
    input  logic [NCH-1:0]      lane_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [18*NCH-1:0]   codeout
`ifdef NBCAC_ENC_CNT_EN
    ,
    output logic [CNT_W-1:0]    word_cnt
`endif
);

    // Output register and skid register state.
    logic                out_valid_q, out_valid_d;
    logic [18*NCH-1:0]   code_q,      code_d;
    logic                sk_full_q,   sk_full_d;
    logic [13*NCH-1:0]   sk_data_q,   sk_data_d;
    logic [NCH-1:0]      sk_en_q,     sk_en_d;
    logic                in_ready_q,  in_ready_d;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_or_free;
    logic                w_load_sk;
    logic                w_load_in;
    logic                w_load_or;
    logic [13*NCH-1:0]   w_enc_data;
    logic [NCH-1:0]      w_enc_en;
    logic [18*NCH-1:0]   w_lane_code;

    assign w_in_xfer  = in_valid & in_ready_q;
    assign w_out_xfer = out_valid_q & out_ready;
    assign w_or_free  = ~out_valid_q | out_ready;

    // A waiting skid word has priority for the output register. Data can go
    // straight to the output register only when the skid register is empty.
    // In that case the skid mux below already selects datain.
    assign w_load_sk  = w_or_free & sk_full_q;
    assign w_load_in  = w_or_free & ~sk_full_q & w_in_xfer;
    assign w_load_or  = w_load_sk | w_load_in;

    assign w_enc_data = sk_full_q ? sk_data_q : datain;
    assign w_enc_en   = sk_full_q ? sk_en_q   : lane_en;

    // One encoder per lane. The lanes are fully independent.
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_lane
            nbcac_13di_encoder_core u_core (
                .data_i (w_enc_data[13*k +: 13]),
                .code_o (w_lane_code[18*k +: 18])
            );
        end
    endgenerate

    // Next-state logic for the output register, the skid register and in_ready.
    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        sk_full_d   = sk_full_q;
        sk_data_d   = sk_data_q;
        sk_en_d     = sk_en_q;

        if (w_load_sk) begin
            sk_full_d = 1'b0;
        end else if (w_in_xfer && !w_or_free) begin
            sk_data_d = datain;
            sk_en_d   = lane_en;
            sk_full_d = 1'b1;
        end

        if (w_load_or) begin
            out_valid_d = 1'b1;
            for (int k = 0; k < NCH; k++) begin
                if (w_enc_en[k]) begin
                    code_d[18*k +: 18] = w_lane_code[18*k +: 18];
                end
            end
        end else if (w_out_xfer) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = ~sk_full_d;
    end

    // State registers. Reset is asynchronous and discards every buffered word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            sk_full_q   <= 1'b0;
            sk_data_q   <= '0;
            sk_en_q     <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            sk_full_q   <= sk_full_d;
            sk_data_q   <= sk_data_d;
            sk_en_q     <= sk_en_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign codeout   = code_q;

`ifdef NBCAC_ENC_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = w_out_xfer ? cnt_q + 1'b1 : cnt_q;

    // Count completed output transfers. The counter wraps naturally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
